// File: rtl/downcounter16_4.sv
// Four independent loadable down counters (countdown timers) sharing clk/reset.
// Each channel counts to terminal count and either stops in DONE or reloads periodically.
module downcounter16_4 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       load,
  input  logic [3:0]       auto,
  input  logic [3:0]       en,
  input  logic [WIDTH-1:0] ld_val0,
  input  logic [WIDTH-1:0] ld_val1,
  input  logic [WIDTH-1:0] ld_val2,
  input  logic [WIDTH-1:0] ld_val3,
  output logic [WIDTH-1:0] cnt0_16,
  output logic [WIDTH-1:0] cnt1_16,
  output logic [WIDTH-1:0] cnt2_16,
  output logic [WIDTH-1:0] cnt3_16,
  output logic [3:0]       tc,
  output logic [3:0]       busy
);

  localparam int unsigned NCH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q  [NCH];
  logic [WIDTH-1:0] count_q  [NCH];
  logic [WIDTH-1:0] reload_q [NCH];
  logic             mode_q   [NCH];
  logic [WIDTH-1:0] ld_val   [NCH];

  assign ld_val[0] = ld_val0;
  assign ld_val[1] = ld_val1;
  assign ld_val[2] = ld_val2;
  assign ld_val[3] = ld_val3;

  assign cnt0_16 = count_q[0];
  assign cnt1_16 = count_q[1];
  assign cnt2_16 = count_q[2];
  assign cnt3_16 = count_q[3];

  // Per-channel state machine; load beats expiry, so a reload on the expiry
  // cycle suppresses the tc pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= ST_IDLE;
        count_q[i]  <= '0;
        reload_q[i] <= '0;
        mode_q[i]   <= 1'b0;
      end
      tc   <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        tc[i] <= 1'b0;
        if (load[i]) begin
          if (ld_val[i] != '0) begin
            count_q[i]  <= ld_val[i];
            reload_q[i] <= ld_val[i];
            mode_q[i]   <= auto[i];
            state_q[i]  <= ST_RUN;
            busy[i]     <= 1'b1;
          end else begin
            count_q[i]  <= '0;
            state_q[i]  <= ST_IDLE;
            busy[i]     <= 1'b0;
          end
        end else if (state_q[i] == ST_RUN && en[i]) begin
          if (count_q[i] > WIDTH'(1)) begin
            count_q[i] <= count_q[i] - WIDTH'(1);
          end else if (mode_q[i]) begin
            count_q[i] <= reload_q[i];
            tc[i]      <= 1'b1;
          end else begin
            count_q[i] <= '0;
            state_q[i] <= ST_DONE;
            busy[i]    <= 1'b0;
            tc[i]      <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_downcounter16_4.sv
// Bench for downcounter16_4: scenario tasks push expected per-channel outputs,
// a monitor pops and compares them one step after each rising edge.
module tb_downcounter16_4;

  logic        clk;
  logic        reset;
  logic [3:0]  load;
  logic [3:0]  auto;
  logic [3:0]  en;
  logic [15:0] ld_val0, ld_val1, ld_val2, ld_val3;
  logic [15:0] cnt0_16, cnt1_16, cnt2_16, cnt3_16;
  logic [3:0]  tc;
  logic [3:0]  busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          ch;
    logic [15:0] cnt;
    logic        tc;
    logic        busy;
    string       name;
  } exp_t;

  exp_t sb[$];

  downcounter16_4 #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .load(load), .auto(auto), .en(en),
    .ld_val0(ld_val0), .ld_val1(ld_val1), .ld_val2(ld_val2), .ld_val3(ld_val3),
    .cnt0_16(cnt0_16), .cnt1_16(cnt1_16), .cnt2_16(cnt2_16), .cnt3_16(cnt3_16),
    .tc(tc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] cnt_of(input int ch);
    case (ch)
      0:       return cnt0_16;
      1:       return cnt1_16;
      2:       return cnt2_16;
      default: return cnt3_16;
    endcase
  endfunction

  task automatic push(input int ch, input logic [15:0] c, input logic t,
                      input logic b, input string name);
    exp_t e;
    e.ch = ch; e.cnt = c; e.tc = t; e.busy = b; e.name = name;
    sb.push_back(e);
  endtask

  // Scoreboard drain: everything pushed before an edge is due right after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (cnt_of(e.ch) !== e.cnt) begin
        errors++;
        $display("FAIL %s ch%0d cnt: got %h want %h", e.name, e.ch, cnt_of(e.ch), e.cnt);
      end
      checks++;
      if (tc[e.ch] !== e.tc) begin
        errors++;
        $display("FAIL %s ch%0d tc: got %b want %b", e.name, e.ch, tc[e.ch], e.tc);
      end
      checks++;
      if (busy[e.ch] !== e.busy) begin
        errors++;
        $display("FAIL %s ch%0d busy: got %b want %b", e.name, e.ch, busy[e.ch], e.busy);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) push(c, 16'h0, 1'b0, 1'b0, "reset");
    step();
    reset = 1'b0;
  endtask

  task automatic test_oneshot();
    load[0] = 1'b1; ld_val0 = 16'd5; auto[0] = 1'b0; en[0] = 1'b1;
    push(0, 16'd5, 1'b0, 1'b1, "oneshot_load");
    push(1, 16'd0, 1'b0, 1'b0, "oneshot_ch1_idle");
    step();
    load[0] = 1'b0;
    for (int v = 4; v >= 1; v--) begin
      push(0, 16'(v), 1'b0, 1'b1, "oneshot_dec");
      step();
    end
    push(0, 16'd0, 1'b1, 1'b0, "oneshot_expire");
    step();
    for (int k = 0; k < 2; k++) begin
      push(0, 16'd0, 1'b0, 1'b0, "oneshot_hold");
      step();
    end
    en[0] = 1'b0;
  endtask

  task automatic test_auto_reload();
    load[1] = 1'b1; ld_val1 = 16'd3; auto[1] = 1'b1; en[1] = 1'b1;
    push(1, 16'd3, 1'b0, 1'b1, "auto_load");
    step();
    load[1] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      push(1, 16'(3 - (k % 3)), (k % 3) == 0, 1'b1, "auto_period");
      step();
    end
    en[1] = 1'b0;
    push(1, 16'd3, 1'b0, 1'b1, "auto_pause");
    step();
    load[1] = 1'b1; ld_val1 = 16'd0;
    push(1, 16'd0, 1'b0, 1'b0, "auto_clear");
    step();
    load[1] = 1'b0;
  endtask

  task automatic test_pause();
    logic [5:0]  en_seq;
    logic [15:0] cnt_seq [6];
    en_seq = 6'b111001;  // applied LSB first: 1,0,0,1,1,1
    cnt_seq = '{16'd3, 16'd3, 16'd3, 16'd2, 16'd1, 16'd0};
    load[2] = 1'b1; ld_val2 = 16'd4; auto[2] = 1'b0; en[2] = 1'b1;
    push(2, 16'd4, 1'b0, 1'b1, "pause_load");
    step();
    load[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      en[2] = en_seq[k];
      push(2, cnt_seq[k], k == 5, k != 5, "pause_seq");
      step();
    end
    en[2] = 1'b1;
    push(2, 16'd0, 1'b0, 1'b0, "pause_done_hold");
    step();
    en[2] = 1'b0;
  endtask

  task automatic test_load_at_expiry();
    load[3] = 1'b1; ld_val3 = 16'd2; auto[3] = 1'b0; en[3] = 1'b1;
    push(3, 16'd2, 1'b0, 1'b1, "lx_load");
    step();
    load[3] = 1'b0;
    push(3, 16'd1, 1'b0, 1'b1, "lx_one");
    step();
    load[3] = 1'b1; ld_val3 = 16'd7;
    push(3, 16'd7, 1'b0, 1'b1, "lx_reload");
    step();
    load[3] = 1'b0;
    push(3, 16'd6, 1'b0, 1'b1, "lx_continue");
    step();
    en[3] = 1'b0;
  endtask

  task automatic test_zero_and_max();
    load[0] = 1'b1; ld_val0 = 16'd9; auto[0] = 1'b0; en[0] = 1'b1;
    push(0, 16'd9, 1'b0, 1'b1, "zm_load9");
    step();
    load[0] = 1'b0;
    push(0, 16'd8, 1'b0, 1'b1, "zm_dec");
    step();
    load[0] = 1'b1; ld_val0 = 16'd0;
    push(0, 16'd0, 1'b0, 1'b0, "zm_load0");
    step();
    load[0] = 1'b0;
    push(0, 16'd0, 1'b0, 1'b0, "zm_idle_ignores_en");
    step();
    load[0] = 1'b1; ld_val0 = 16'hFFFF;
    push(0, 16'hFFFF, 1'b0, 1'b1, "zm_loadmax");
    step();
    load[0] = 1'b0;
    push(0, 16'hFFFE, 1'b0, 1'b1, "zm_max_dec");
    step();
    push(0, 16'hFFFD, 1'b0, 1'b1, "zm_max_dec");
    step();
    en[0] = 1'b0;
  endtask

  task automatic test_back_to_back_reset();
    load = 4'b1111; auto = 4'b0101; en = 4'b1111;
    ld_val0 = 16'd10; ld_val1 = 16'd20; ld_val2 = 16'd30; ld_val3 = 16'd40;
    for (int c = 0; c < 4; c++) push(c, 16'((c + 1) * 10), 1'b0, 1'b1, "par_load");
    step();
    load = 4'b0000;
    for (int k = 1; k <= 2; k++) begin
      for (int c = 0; c < 4; c++) push(c, 16'((c + 1) * 10 - k), 1'b0, 1'b1, "par_dec");
      step();
    end
    reset = 1'b1; load = 4'b1111;
    for (int c = 0; c < 4; c++) push(c, 16'h0, 1'b0, 1'b0, "mid_reset");
    step();
    reset = 1'b0; load = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) push(c, 16'h0, 1'b0, 1'b0, "en_no_restart");
      step();
    end
    en = 4'b0000;
  endtask

  initial begin
    reset = 1'b1; load = '0; auto = '0; en = '0;
    ld_val0 = '0; ld_val1 = '0; ld_val2 = '0; ld_val3 = '0;
    step();
    test_reset();
    test_oneshot();
    test_auto_reload();
    test_pause();
    test_load_at_expiry();
    test_zero_and_max();
    test_back_to_back_reset();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
